// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants for the registered 8:1 multiplexer.
//   WIDTH_DEFAULT : default data width of every input and of the output
//   SEL_A..SEL_H  : select codes that address inputs A..H
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam int WIDTH_DEFAULT = 4;

    localparam logic [2:0] SEL_A = 3'b000;
    localparam logic [2:0] SEL_B = 3'b001;
    localparam logic [2:0] SEL_C = 3'b010;
    localparam logic [2:0] SEL_D = 3'b011;
    localparam logic [2:0] SEL_E = 3'b100;
    localparam logic [2:0] SEL_F = 3'b101;
    localparam logic [2:0] SEL_G = 3'b110;
    localparam logic [2:0] SEL_H = 3'b111;

endpackage : mux_pkg

// File: rtl/mux_out_reg.sv
// -----------------------------------------------------------------------------
// mux_out_reg
// Output register of the 8:1 mux. Holds the selected data word and, when
// MUX_PARITY_EN is defined, its parity bit, both with asynchronous clear.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears q (and p)
//   d      : next data word (already selected)
//   q      : registered data word
//   p      : registered XOR of all bits of d (only with MUX_PARITY_EN)
// -----------------------------------------------------------------------------
module mux_out_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
`ifdef MUX_PARITY_EN
    output logic             p,
`endif
    output logic [WIDTH-1:0] q
);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs as they were just before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

`ifdef MUX_PARITY_EN
    // Parity is taken from d, not q, so it lands in the same cycle as the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= 1'b0;
        end else begin
            p <= ^d;
        end
    end
`endif

endmodule : mux_out_reg

// File: rtl/mux_8to1.sv
// -----------------------------------------------------------------------------
// mux_8to1
// Registered 8:1 multiplexer with one clock of latency.
// Optional feature: define MUX_PARITY_EN to add the registered parity output P.
// Parameters:
//   WIDTH  : width of each data input and of O
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, forces O (and P) to zero
//   A..H   : data inputs, selected by S = 3'b000..3'b111
//   S      : select code, all eight values valid
//   O      : selected data, registered
//   P      : XOR of all bits of O (only with MUX_PARITY_EN)
// -----------------------------------------------------------------------------
module mux_8to1
    import mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] H,
    input  logic [2:0]       S,
`ifdef MUX_PARITY_EN
    output logic             P,
`endif
    output logic [WIDTH-1:0] O
);

    logic [WIDTH-1:0] sel_data;

    // NOTE: sel_data gets a default before the case so no path through this
    // block leaves it unassigned, which would infer a latch.
    always_comb begin
        sel_data = '0;
        case (S)
            SEL_A: sel_data = A;
            SEL_B: sel_data = B;
            SEL_C: sel_data = C;
            SEL_D: sel_data = D;
            SEL_E: sel_data = E;
            SEL_F: sel_data = F;
            SEL_G: sel_data = G;
            SEL_H: sel_data = H;
            default: sel_data = '0;
        endcase
    end

    mux_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sel_data),
`ifdef MUX_PARITY_EN
        .p     (P),
`endif
        .q     (O)
    );

endmodule : mux_8to1

// File: tb/tb_mux_8to1.sv
// -----------------------------------------------------------------------------
// tb_mux_8to1
// Self-checking bench for mux_8to1 (WIDTH = 4). Inputs are driven and outputs
// sampled 1 time unit after the rising edge. Parity checks are compiled in
// only when MUX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_mux_8to1;

    localparam int W = 4;

    typedef struct {
        logic [2:0]   s;
        logic [W-1:0] exp_o;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a, b, c, d, e, f, g, h;
    logic [2:0]   s;
    logic [W-1:0] o;
`ifdef MUX_PARITY_EN
    logic         p;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mux_8to1 #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a),
        .B     (b),
        .C     (c),
        .D     (d),
        .E     (e),
        .F     (f),
        .G     (g),
        .H     (h),
        .S     (s),
`ifdef MUX_PARITY_EN
        .P     (p),
`endif
        .O     (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_o(input string name, input logic [W-1:0] exp);
        check(name, 32'(o), 32'(exp));
`ifdef MUX_PARITY_EN
        check({name, "_parity"}, 32'(p), 32'(^exp));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        // Expected O for the S sweep with A..H = 8,9,a,b,c,e,d,f.
        vecs[0] = '{3'b000, 4'h8};
        vecs[1] = '{3'b001, 4'h9};
        vecs[2] = '{3'b010, 4'ha};
        vecs[3] = '{3'b011, 4'hb};
        vecs[4] = '{3'b100, 4'hc};
        vecs[5] = '{3'b101, 4'he};
        vecs[6] = '{3'b110, 4'hd};
        vecs[7] = '{3'b111, 4'hf};

        // Reset asserted from time 0 with every input nonzero.
        rst_n = 1'b0;
        a = 4'h5; b = 4'h6; c = 4'h7; d = 4'h9;
        e = 4'ha; f = 4'hb; g = 4'hc; h = 4'hd;
        s = 3'b111;
        #2;
        check_o("reset_immediate", 4'h0);
        tick();
        tick();
        check_o("reset_held_over_edges", 4'h0);

        // Release, then the first edge loads A.
        rst_n = 1'b1;
        a = 4'h1;
        s = 3'b000;
        tick();
        check_o("first_edge_after_reset", 4'h1);

        // Table-driven sweep of all eight select codes.
        a = 4'h8; b = 4'h9; c = 4'ha; d = 4'hb;
        e = 4'hc; f = 4'he; g = 4'hd; h = 4'hf;
        for (int i = 0; i < 8; i++) begin
            s = vecs[i].s;
            tick();
            check_o($sformatf("sweep_s%0d", i), vecs[i].exp_o);
        end

        // Latency: a new S must not reach O before the next edge.
        s = 3'b000;
        #3;
        check_o("no_early_update", 4'hf);
        tick();
        check_o("one_cycle_latency", 4'h8);

        // Data change between edges is held off until the next edge.
        s = 3'b101;
        f = 4'he;
        tick();
        check_o("hold_f_e", 4'he);
        #2;
        f = 4'h3;
        #2;
        check_o("mid_cycle_f_change", 4'he);
        tick();
        check_o("f_change_after_edge", 4'h3);

        // Simultaneous change of S and the newly selected data.
        s = 3'b010;
        c = 4'h7;
        tick();
        check_o("simultaneous_s_data", 4'h7);

        // Reset between edges clears O without waiting for the clock.
        s = 3'b111;
        h = 4'hf;
        tick();
        check_o("load_f_before_reset", 4'hf);
        #2;
        rst_n = 1'b0;
        #1;
        check_o("async_reset_mid_cycle", 4'h0);
        tick();
        check_o("reset_held_mid_op", 4'h0);
        rst_n = 1'b1;
        tick();
        check_o("reload_after_reset", 4'hf);

`ifdef MUX_PARITY_EN
        // Hand-computed parity values: 4'he has three ones, 4'hc has two.
        s = 3'b101;
        f = 4'he;
        tick();
        check("parity_o_e", 32'(o), 32'h0000000e);
        check("parity_p_e", 32'(p), 32'h1);
        s = 3'b110;
        g = 4'hc;
        tick();
        check("parity_o_c", 32'(o), 32'h0000000c);
        check("parity_p_c", 32'(p), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_mux_8to1
